// File: rtl/onehot_priority_serializer_if.sv
// Handshake bundle for onehot_priority_serializer: a request vector goes in,
// and one set-bit index comes out per output beat.
interface onehot_priority_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/onehot_priority_serializer.sv
// Serializes every set bit of a request vector into one index per handshake,
// in priority order. Optional one-hot checker (vec_err) under `ONEHOT_CHECK_EN.
module onehot_priority_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  onehot_priority_serializer_if.slave  bus
`ifdef ONEHOT_CHECK_EN
  ,
  output logic                         vec_err
`endif
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] clr_mask;
  logic [IDX_W-1:0] sel;
  logic             drain;
  logic             last;
  logic             out_hs;
  logic             in_rdy;
  logic             accept;

  // Scan from the low-priority end so the highest-priority set bit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (LSB_FIRST) begin
        if (pend_q[WIDTH-1-i]) sel = IDX_W'(WIDTH-1-i);
      end else begin
        if (pend_q[i]) sel = IDX_W'(i);
      end
    end
  end

  assign drain    = (state_q == DRAIN);
  assign last     = drain && $onehot(pend_q);
  assign out_hs   = drain && bus.out_ready;
  assign in_rdy   = !drain || (bus.out_ready && last);
  assign accept   = bus.in_valid && in_rdy;
  assign clr_mask = WIDTH'(1) << sel;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = drain;
  assign bus.out_idx   = drain ? sel : '0;
  assign bus.out_last  = last;
  assign bus.busy      = drain;

  // An accept on the last-index beat overrides the clear, giving zero-bubble hand-over.
  always_comb begin
    pend_d  = pend_q;
    state_d = state_q;
    if (out_hs) begin
      pend_d = pend_q & ~clr_mask;
      if (last) state_d = IDLE;
    end
    if (accept) begin
      pend_d  = bus.in_vec;
      state_d = (|bus.in_vec) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && !$onehot(bus.in_vec);
  end

  assign vec_err = err_q;
`endif
endmodule

// File: tb/tb_onehot_priority_serializer.sv
// Randomized + directed bench: three serializers (8 LSB-first, 8 MSB-first,
// 13 LSB-first) checked every cycle against a queue-based index model.
module tb_onehot_priority_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_priority_serializer_if #(.WIDTH(8))  ifa ();
  onehot_priority_serializer_if #(.WIDTH(8))  ifb ();
  onehot_priority_serializer_if #(.WIDTH(13)) ifc ();

  logic        v8 = 1'b0, r8 = 1'b1;
  logic [7:0]  vec8 = '0;
  logic        v13 = 1'b0, r13 = 1'b1;
  logic [12:0] vec13 = '0;

  assign ifa.in_valid = v8;   assign ifa.in_vec = vec8;   assign ifa.out_ready = r8;
  assign ifb.in_valid = v8;   assign ifb.in_vec = vec8;   assign ifb.out_ready = r8;
  assign ifc.in_valid = v13;  assign ifc.in_vec = vec13;  assign ifc.out_ready = r13;

`ifdef ONEHOT_CHECK_EN
  logic erra, errb, errc;
`endif

  onehot_priority_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
`ifdef ONEHOT_CHECK_EN
    , .vec_err(erra)
`endif
  );
  onehot_priority_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
`ifdef ONEHOT_CHECK_EN
    , .vec_err(errb)
`endif
  );
  onehot_priority_serializer #(.WIDTH(13), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
`ifdef ONEHOT_CHECK_EN
    , .vec_err(errc)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per unit, the list of indices still owed for the current vector.
  int mq[3][$];
  bit merr[3];
  int cap[3][$];

  function automatic void get_in(input int u, output bit iv, output logic [12:0] vec, output bit ord);
    case (u)
      0, 1:    begin iv = v8;  vec = {5'b0, vec8}; ord = r8;  end
      default: begin iv = v13; vec = vec13;        ord = r13; end
    endcase
  endfunction

  function automatic void get_out(input int u, output bit ov, output int idx, output bit lst,
                                  output bit ir, output bit bsy, output bit ord);
    case (u)
      0: begin ov = ifa.out_valid; idx = int'(ifa.out_idx); lst = ifa.out_last;
               ir = ifa.in_ready; bsy = ifa.busy; ord = r8; end
      1: begin ov = ifb.out_valid; idx = int'(ifb.out_idx); lst = ifb.out_last;
               ir = ifb.in_ready; bsy = ifb.busy; ord = r8; end
      default: begin ov = ifc.out_valid; idx = int'(ifc.out_idx); lst = ifc.out_last;
               ir = ifc.in_ready; bsy = ifc.busy; ord = r13; end
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int u = 0; u < 3; u++) begin
        bit iv, ord, acc, exp_ir;
        logic [12:0] vec;
        int w;
        if (!rst_n) begin
          mq[u].delete();
          merr[u] = 1'b0;
          continue;
        end
        get_in(u, iv, vec, ord);
        w = (u == 2) ? 13 : 8;
        exp_ir = (mq[u].size() == 0) || (ord && mq[u].size() == 1);
        acc = iv && exp_ir;
        if (mq[u].size() > 0 && ord) void'(mq[u].pop_front());
        merr[u] = acc && ($countones(vec) != 1);
        if (acc) begin
          if (u != 1) begin
            for (int i = 0; i < w; i++) if (vec[i]) mq[u].push_back(i);
          end else begin
            for (int i = w - 1; i >= 0; i--) if (vec[i]) mq[u].push_back(i);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        bit ov, lst, ir, bsy, ord, exp_ov;
        int idx;
        get_out(u, ov, idx, lst, ir, bsy, ord);
        exp_ov = mq[u].size() > 0;
        chk($sformatf("u%0d.out_valid", u), int'(ov), int'(exp_ov));
        chk($sformatf("u%0d.busy", u), int'(bsy), int'(exp_ov));
        chk($sformatf("u%0d.out_last", u), int'(lst), int'(mq[u].size() == 1));
        chk($sformatf("u%0d.in_ready", u), int'(ir),
            int'(!exp_ov || (ord && mq[u].size() == 1)));
        if (exp_ov) chk($sformatf("u%0d.out_idx", u), idx, mq[u][0]);
`ifdef ONEHOT_CHECK_EN
        case (u)
          0: chk("u0.vec_err", int'(erra), int'(merr[0]));
          1: chk("u1.vec_err", int'(errb), int'(merr[1]));
          default: chk("u2.vec_err", int'(errc), int'(merr[2]));
        endcase
`endif
        if (ov && ord && rst_n) cap[u].push_back(idx);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send8(input logic [7:0] v);
    int n = 0;
    v8 = 1'b1; vec8 = v;
    while (!ifa.in_ready && n < 50) begin step(); n++; end
    chk("u0.accept_timeout", int'(n < 50), 1);
    step();
    v8 = 1'b0;
  endtask

  task automatic send13(input logic [12:0] v);
    int n = 0;
    v13 = 1'b1; vec13 = v;
    while (!ifc.in_ready && n < 50) begin step(); n++; end
    chk("u2.accept_timeout", int'(n < 50), 1);
    step();
    v13 = 1'b0;
  endtask

  // Pins the captured handshake sequence to hand-computed literals.
  task automatic chkseq(input string nm, input int u, input int n,
                        input int e0 = 0, input int e1 = 0, input int e2 = 0);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({nm, ".count"}, cap[u].size(), n);
    for (int i = 0; i < n && i < cap[u].size(); i++)
      chk($sformatf("%s.idx%0d", nm, i), cap[u][i], e[i]);
    cap[u].delete();
  endtask

  initial begin
    step(2);
    chk("reset.out_valid", int'(ifa.out_valid), 0);
    chk("reset.out_idx", int'(ifa.out_idx), 0);
    chk("reset.out_last", int'(ifa.out_last), 0);
    chk("reset.busy", int'(ifa.busy), 0);
    rst_n = 1'b1;
    step();
    chk("reset.in_ready", int'(ifa.in_ready), 1);

    r8 = 1'b1;
    send8(8'h04);
    chk("single.out_idx_next_cycle", int'(ifa.out_idx), 2);
    chk("single.out_last_next_cycle", int'(ifa.out_last), 1);
    step(3);
    chkseq("single_a", 0, 1, 2);
    chkseq("single_b", 1, 1, 2);

    send8(8'h92);
    step(4);
    chkseq("multi_a", 0, 3, 1, 4, 7);
    chkseq("multi_b", 1, 3, 7, 4, 1);

    r8 = 1'b0;
    send8(8'h60);
    step(3);
    chk("stall.out_idx", int'(ifa.out_idx), 5);
    chk("stall.in_ready", int'(ifa.in_ready), 0);
    r8 = 1'b1;
    step(3);
    chkseq("stall_a", 0, 2, 5, 6);
    chkseq("stall_b", 1, 2, 6, 5);

    send8(8'h81);
    send8(8'h08);
    step(3);
    chkseq("b2b_a", 0, 3, 0, 7, 3);
    chkseq("b2b_b", 1, 3, 7, 0, 3);

    send8(8'h00);
    chk("zero.out_valid", int'(ifa.out_valid), 0);
    chk("zero.in_ready", int'(ifa.in_ready), 1);
    step(2);
    chkseq("zero_a", 0, 0);

    send8(8'h03);
    step(3);
    chkseq("two_a", 0, 2, 0, 1);
    chkseq("two_b", 1, 2, 1, 0);

    r13 = 1'b1;
    send13(13'h1001);
    step();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
    chk("w13.post_reset_valid", int'(ifc.out_valid), 0);
    chk("w13.post_reset_ready", int'(ifc.in_ready), 1);
    chkseq("w13_reset", 2, 1, 0);
    send13(13'h1000);
    step(3);
    chkseq("w13_top", 2, 1, 12);

    for (int c = 0; c < 600; c++) begin
      v8    = ($urandom_range(0, 2) != 0);
      vec8  = 8'($urandom & $urandom);
      r8    = ($urandom_range(0, 3) != 0);
      v13   = ($urandom_range(0, 2) != 0);
      vec13 = 13'($urandom & $urandom);
      r13   = ($urandom_range(0, 3) != 0);
      step();
    end
    v8 = 1'b0; v13 = 1'b0; r8 = 1'b1; r13 = 1'b1;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
